// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage sitting directly after the PC register. It samples
// the PC, issues a word-aligned request to instruction memory, captures the
// returned word into the IF/ID pipeline register and pulses pc_advance so the
// upstream next-PC mux selects PC+4. Decode stall and branch flush are honoured;
// a one-entry skid buffer holds a response that arrives while IF/ID is blocked.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   : a REQ that sees no ack for TIMEOUT_CYCLES cycles is abandoned,
//               NOP_INSTR is delivered instead and fetch_err becomes sticky.
//   undefined : REQ waits indefinitely, fetch_err is tied to 0.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   pc_in         : current PC from the PC register
//   imem_req      : instruction memory request (registered)
//   imem_addr     : request address, PC with bits [1:0] cleared
//   imem_ack      : response valid, only looked at while imem_req=1
//   imem_rdata    : instruction word, valid with imem_ack
//   id_stall      : decode cannot accept a new IF/ID word this cycle
//   flush         : one-cycle branch/jump pulse, discards fetch state
//   if_id_instr   : IF/ID instruction word
//   if_id_pc4     : IF/ID fetch address + 4
//   if_id_valid   : IF/ID holds a valid instruction
//   pc_advance    : one-cycle pulse, next-PC mux selects PC+4
//   fetch_err     : sticky timeout flag
//   dbg_state     : current FSM state (IDLE=0, REQ=1, HOLD=2, ADV=3)
//
// Handshake: imem_req rises with a stable imem_addr and both stay unchanged
// until a rising edge where imem_ack=1; that edge completes the transfer and
// imem_req drops at it. Acks while imem_req=0 have no effect. On the IF/ID
// side a word is consumed at an edge where if_id_valid=1 and id_stall=0.
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        flush,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        pc_advance,
    output logic        fetch_err,
    output logic [1:0]  dbg_state
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ADV  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        flush_pending;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;

    logic        timeout_hit;
    logic        resp;
    logic        discard;
    logic        slot_free;
    logic        load_mem;
    logic        load_skid;
    logic        to_hold;
    logic        consume;
    logic [31:0] resp_data;
    logic [31:0] addr_plus4;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;

    // Counts REQ cycles without ack; held at 0 outside REQ so every REQ entry
    // starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (state != REQ) begin
            wait_cnt <= 8'd0;
        end else if (!imem_ack && !timeout_hit) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == REQ) && !imem_ack && (wait_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // A timeout behaves exactly like an ack carrying NOP_INSTR.
    assign resp       = (state == REQ) && (imem_ack || timeout_hit);
    assign resp_data  = timeout_hit ? NOP_INSTR : imem_rdata;
    assign addr_plus4 = imem_addr + 32'd4;
    assign discard    = flush || flush_pending;
    assign slot_free  = !if_id_valid || !id_stall;
    assign load_mem   = resp && !discard && slot_free;
    assign to_hold    = resp && !discard && !slot_free;
    assign load_skid  = (state == HOLD) && !flush && !id_stall;
    assign consume    = if_id_valid && !id_stall;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic; flush outranks ack, stall and HOLD
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                // On a flush stay here one more cycle so the branch target
                // is what gets sampled.
                if (!flush) state_next = REQ;
            end
            REQ: begin
                if (resp) begin
                    if (discard)        state_next = IDLE;
                    else if (slot_free) state_next = ADV;
                    else                state_next = HOLD;
                end
            end
            HOLD: begin
                if (flush)          state_next = IDLE;
                else if (!id_stall) state_next = ADV;
            end
            ADV: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Memory request side
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req      <= 1'b0;
            imem_addr     <= 32'd0;
            flush_pending <= 1'b0;
        end else begin
            if (state == IDLE && !flush) begin
                imem_req  <= 1'b1;
                imem_addr <= pc_in & 32'hFFFF_FFFC;
            end else if (resp) begin
                imem_req <= 1'b0;
            end

            // An outstanding request cannot be cancelled, so a flush during
            // the wait is remembered and the eventual response dropped.
            if (resp) begin
                flush_pending <= 1'b0;
            end else if (state == REQ && flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer, IF/ID register and status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_instr  <= 32'd0;
            skid_pc4    <= 32'd0;
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            pc_advance  <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            if (to_hold) begin
                skid_instr <= resp_data;
                skid_pc4   <= addr_plus4;
            end else if (state == HOLD && flush) begin
                skid_instr <= 32'd0;
                skid_pc4   <= 32'd0;
            end

            if (load_mem) begin
                if_id_instr <= resp_data;
                if_id_pc4   <= addr_plus4;
            end else if (load_skid) begin
                if_id_instr <= skid_instr;
                if_id_pc4   <= skid_pc4;
            end

            // Flush clears, a new word beats consumption at the same edge.
            if (flush) begin
                if_id_valid <= 1'b0;
            end else if (load_mem || load_skid) begin
                if_id_valid <= 1'b1;
            end else if (consume) begin
                if_id_valid <= 1'b0;
            end

            pc_advance <= (state_next == ADV);

            if (timeout_hit) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        flush;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        pc_advance;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  if_fetch_stage #(
    .NOP_INSTR      (NOP),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_stall    (id_stall),
    .flush       (flush),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .pc_advance  (pc_advance),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_in = 32'h0040_0000; imem_ack = 1'b0; imem_rdata = 32'd0;
    id_stall = 1'b0; flush = 1'b0;
    repeat (2) tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr got=%08h exp=00000000", imem_addr); end
    total++; if (if_id_instr !== 32'd0 || if_id_pc4 !== 32'd0) begin bad++; $display("FAIL rst_ifid got=%08h/%08h exp=0/0", if_id_instr, if_id_pc4); end
    total++; if (if_id_valid !== 1'b0 || pc_advance !== 1'b0 || fetch_err !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b%b exp=000", if_id_valid, pc_advance, fetch_err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL t1_req got=%0h exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL t1_addr got=%08h exp=00400000", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    total++; if (if_id_instr !== 32'h2008_0005) begin bad++; $display("FAIL t1_instr got=%08h exp=20080005", if_id_instr); end
    total++; if (if_id_pc4 !== 32'h0040_0004) begin bad++; $display("FAIL t1_pc4 got=%08h exp=00400004", if_id_pc4); end
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%0h exp=1", if_id_valid); end
    total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL t1_adv got=%0h exp=1", pc_advance); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL t1_req_drop got=%0h exp=0", imem_req); end
    imem_ack = 1'b0; pc_in = 32'h0040_0004;
    tick();
    total++; if (pc_advance !== 1'b0) begin bad++; $display("FAIL t1_adv_end got=%0h exp=0", pc_advance); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL t1_consumed got=%0h exp=0", if_id_valid); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL t1_idle got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_wait_ack();
    int pulses;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin bad++; $display("FAIL t2_req got=%0h/%08h exp=1/00400004", imem_req, imem_addr); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pc_advance === 1'b1) pulses++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin bad++; $display("FAIL t2_wait%0d got=%0h/%08h exp=1/00400004", i, imem_req, imem_addr); end
      total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL t2_novalid%0d got=%0h exp=0", i, if_id_valid); end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0085_1020;
    tick();
    if (pc_advance === 1'b1) pulses++;
    total++; if (if_id_instr !== 32'h0085_1020 || if_id_pc4 !== 32'h0040_0008) begin bad++; $display("FAIL t2_load got=%08h/%08h exp=00851020/00400008", if_id_instr, if_id_pc4); end
    imem_ack = 1'b0; pc_in = 32'h0040_0008;
    tick();
    if (pc_advance === 1'b1) pulses++;
    total++; if (pulses !== 1) begin bad++; $display("FAIL t2_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_stall_hold();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
    tick();
    total++; if (if_id_instr !== 32'hAAAA_0001 || if_id_valid !== 1'b1) begin bad++; $display("FAIL t3_first got=%08h/%0h exp=aaaa0001/1", if_id_instr, if_id_valid); end
    imem_ack = 1'b0; id_stall = 1'b1; pc_in = 32'h0040_000C;
    tick();
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL t3_kept got=%0h exp=1", if_id_valid); end
    tick();
    total++; if (imem_addr !== 32'h0040_000C || imem_req !== 1'b1) begin bad++; $display("FAIL t3_req got=%08h/%0h exp=0040000c/1", imem_addr, imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'h8C09_0000;
    tick();
    imem_ack = 1'b0;
    total++; if (dbg_state !== 2'd2 || imem_req !== 1'b0) begin bad++; $display("FAIL t3_hold got=%0d/%0h exp=2/0", dbg_state, imem_req); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if_id_instr !== 32'hAAAA_0001 || if_id_valid !== 1'b1 || pc_advance !== 1'b0) begin bad++; $display("FAIL t3_stalled%0d got=%08h/%0h/%0h exp=aaaa0001/1/0", i, if_id_instr, if_id_valid, pc_advance); end
    end
    id_stall = 1'b0;
    tick();
    total++; if (if_id_instr !== 32'h8C09_0000 || if_id_pc4 !== 32'h0040_0010) begin bad++; $display("FAIL t3_skid got=%08h/%08h exp=8c090000/00400010", if_id_instr, if_id_pc4); end
    total++; if (if_id_valid !== 1'b1 || pc_advance !== 1'b1) begin bad++; $display("FAIL t3_adv got=%0h/%0h exp=1/1", if_id_valid, pc_advance); end
    pc_in = 32'h0040_0010;
    tick();
    total++; if (pc_advance !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL t3_idle got=%0h/%0d exp=0/0", pc_advance, dbg_state); end
  endtask

  task automatic test_flush_req();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
    tick();
    imem_ack = 1'b0; id_stall = 1'b1; pc_in = 32'h0040_0014;
    tick();
    tick();
    total++; if (imem_addr !== 32'h0040_0014 || if_id_valid !== 1'b1) begin bad++; $display("FAIL t4_pre got=%08h/%0h exp=00400014/1", imem_addr, if_id_valid); end
    tick();
    flush = 1'b1; pc_in = 32'h0040_0100;
    tick();
    flush = 1'b0;
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL t4_flush_valid got=%0h exp=0", if_id_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0014 || dbg_state !== 2'd1) begin bad++; $display("FAIL t4_still_req got=%0h/%08h/%0d exp=1/00400014/1", imem_req, imem_addr, dbg_state); end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; id_stall = 1'b0;
    tick();
    imem_ack = 1'b0;
    total++; if (imem_req !== 1'b0 || dbg_state !== 2'd0 || pc_advance !== 1'b0) begin bad++; $display("FAIL t4_discard got=%0h/%0d/%0h exp=0/0/0", imem_req, dbg_state, pc_advance); end
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h1111_0000) begin bad++; $display("FAIL t4_nodata got=%0h/%08h exp=0/11110000", if_id_valid, if_id_instr); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100 || pc_advance !== 1'b0) begin bad++; $display("FAIL t4_target got=%0h/%08h/%0h exp=1/00400100/0", imem_req, imem_addr, pc_advance); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
    tick();
    total++; if (if_id_pc4 !== 32'h0040_0104 || pc_advance !== 1'b1) begin bad++; $display("FAIL t4_after got=%08h/%0h exp=00400104/1", if_id_pc4, pc_advance); end
    imem_ack = 1'b0; pc_in = 32'h0040_0104;
    tick();
  endtask

  task automatic test_addr_wrap();
    pc_in = 32'hFFFF_FFFE;
    tick();
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL t5_addr got=%08h exp=fffffffc", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h03E0_0008;
    tick();
    total++; if (if_id_pc4 !== 32'h0000_0000 || if_id_instr !== 32'h03E0_0008) begin bad++; $display("FAIL t5_pc4 got=%08h/%08h exp=00000000/03e00008", if_id_pc4, if_id_instr); end
    imem_ack = 1'b0; pc_in = 32'h0040_0200;
    tick();
  endtask

  task automatic test_timeout();
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin bad++; $display("FAIL t6_req got=%0h/%08h exp=1/00400200", imem_req, imem_addr); end
`ifdef FETCH_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      total++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin bad++; $display("FAIL t6_wait%0d got=%0h/%0h exp=1/0", i, imem_req, fetch_err); end
    end
    tick();
    total++; if (imem_req !== 1'b0 || fetch_err !== 1'b1) begin bad++; $display("FAIL t6_timeout got=%0h/%0h exp=0/1", imem_req, fetch_err); end
    total++; if (if_id_instr !== NOP || if_id_valid !== 1'b1 || if_id_pc4 !== 32'h0040_0204 || pc_advance !== 1'b1) begin bad++; $display("FAIL t6_nop got=%08h/%0h/%08h/%0h exp=%08h/1/00400204/1", if_id_instr, if_id_valid, if_id_pc4, pc_advance, NOP); end
    pc_in = 32'h0040_0204;
    tick();
    total++; if (fetch_err !== 1'b1 || pc_advance !== 1'b0) begin bad++; $display("FAIL t6_sticky got=%0h/%0h exp=1/0", fetch_err, pc_advance); end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (imem_req !== 1'b1 || fetch_err !== 1'b0 || pc_advance !== 1'b0) begin bad++; $display("FAIL t6_nowait%0d got=%0h/%0h/%0h exp=1/0/0", i, imem_req, fetch_err, pc_advance); end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_000C;
    tick();
    imem_ack = 1'b0;
    total++; if (if_id_instr !== 32'h0000_000C || if_id_pc4 !== 32'h0040_0204 || fetch_err !== 1'b0) begin bad++; $display("FAIL t6_late got=%08h/%08h/%0h exp=0000000c/00400204/0", if_id_instr, if_id_pc4, fetch_err); end
    pc_in = 32'h0040_0204;
    tick();
`endif
  endtask

  task automatic test_async_reset();
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL t7_req got=%0h exp=1", imem_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0 || dbg_state !== 2'd0 || fetch_err !== 1'b0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL t7_async got=%0h/%0d/%0h/%0h exp=0/0/0/0", imem_req, dbg_state, fetch_err, if_id_valid); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_wait_ack();
    test_stall_hold();
    test_flush_req();
    test_addr_wrap();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly downstream of the PC register. It samples the current PC and issues a word-aligned request to instruction memory over a req/ack handshake. It captures the returned instruction into the IF/ID pipeline register, which honours stall and flush from decode/branch logic. It also drives pc_advance, which the upstream next-PC mux uses to select PC+4; when pc_advance is 0 the mux holds the PC.

Parameters:
NOP_INSTR, 32'h0000_0000, instruction word inserted on fetch timeout (sll $0,$0,0).
TIMEOUT_CYCLES, 16, maximum REQ cycles without imem_ack before timeout. Range 2..255. Used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
pc_in  in  32  current PC from the PC register
imem_req  out  1  instruction memory request
imem_addr  out  32  request address, {pc[31:2],2'b00}
imem_ack  in  1  memory response valid; sampled only while imem_req=1
imem_rdata  in  32  instruction word; valid with imem_ack
id_stall  in  1  decode cannot accept a new IF/ID word this cycle
flush  in  1  one-cycle pulse: branch/jump taken, discard fetch state
if_id_instr  out  32  IF/ID instruction
if_id_pc4  out  32  IF/ID fetch address + 4
if_id_valid  out  1  IF/ID holds a valid instruction
pc_advance  out  1  one-cycle pulse: next-PC mux selects PC+4
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset: clk is the only clock and rst is asynchronous, active-high. While rst=1, all outputs are 0, state is IDLE, and the skid buffer, flush_pending and the counter are 0.
- FSM states: IDLE, REQ, HOLD, ADV. All outputs are registered.
- IDLE: sample pc_in. At the edge, imem_addr<={pc_in[31:2],2'b00}, imem_req<=1, go to REQ. pc_in[1:0] are ignored.
- REQ: imem_req and imem_addr are held stable until the ack edge. On an edge with imem_ack=1:
  - If flush=1 or flush_pending=1: discard imem_rdata, imem_req<=0, clear flush_pending, go to IDLE. No pc_advance.
  - Else if the slot is free (if_id_valid=0 or id_stall=0): if_id_instr<=imem_rdata, if_id_pc4<=imem_addr+4 (mod 2^32, so 0xFFFFFFFC gives 0), if_id_valid<=1, imem_req<=0, go to ADV.
  - Else: store imem_rdata and imem_addr+4 in the skid buffer, imem_req<=0, go to HOLD.
- HOLD: on the first edge with id_stall=0, move the buffer into IF/ID (valid<=1) and go to ADV.
- ADV: pc_advance=1 for exactly this cycle. The PC register loads PC+4 at the end of the cycle. Next state is IDLE, so the new PC is sampled the cycle after ADV.
- Decode consumption: IF/ID is consumed at an edge where if_id_valid=1 and id_stall=0. if_id_valid<=0 at that edge unless a new word loads at the same edge (load wins).
- Flush has top priority over ack, stall and HOLD:
  - if_id_valid<=0 at the flush edge.
  - REQ without ack: set flush_pending and stay in REQ. The handshake must complete; the response is discarded.
  - HOLD: drop the buffer, go to IDLE.
  - ADV: go to IDLE. The upstream mux gives the branch target priority over pc_advance.
  - IDLE: no state change; the next IDLE samples the target.
- Throughput: with a zero-wait ack (ack in the first REQ cycle) and no stalls, one instruction every 3 cycles.
- Reset asserted mid-REQ: imem_req drops immediately (asynchronously). Memory must tolerate an abandoned request.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on REQ entry and increments on each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: imem_req<=0, fetch_err<=1 (sticky until rst), and NOP_INSTR is delivered as a normal response (IF/ID or HOLD, then ADV).
  - Under a pending flush, a timeout discards the fetch and goes to IDLE.
  - Acks arriving while imem_req=0 are ignored.
- Undefined: REQ waits indefinitely, no counter is built, and fetch_err is tied to 0.

Test Plan:
1. Release rst, pc_in=0x0040_0000, ack in the first REQ cycle with rdata=0x2008_0005 -> imem_req high 1 cycle after release; next edge if_id_instr=0x2008_0005, if_id_pc4=0x0040_0004, if_id_valid=1; pc_advance=1 for exactly the following cycle.
2. Ack after 4 wait cycles -> imem_addr stable throughout; IF/ID updates only at the ack edge; exactly one pc_advance pulse.
3. if_id_valid=1 with id_stall held high 5 cycles, second ack rdata=0x8C09_0000 -> HOLD entered, IF/ID unchanged while stalled; first edge with id_stall=0 loads 0x8C09_0000; then pc_advance.
4. flush during a 3-cycle wait in REQ -> if_id_valid=0 at the flush edge; returning word discarded; no pc_advance; next request uses the new pc_in (0x0040_0100).
5. pc_in=0xFFFF_FFFE -> imem_addr=0xFFFF_FFFC, if_id_pc4=0x0000_0000.
6. FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no ack -> imem_req drops after 16 REQ cycles; if_id_instr=NOP_INSTR, valid=1, fetch_err=1 until rst; pc_advance pulses. Without the macro, imem_req stays high and fetch_err=0.
